hilo_seq_ctrl: RTL
==================

Name: hilo_seq_ctrl

Overview:
- Sequencer for the HI/LO write path of the 54-instruction CPU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID, launches and waits on the multi-cycle multiplier/divider, then drives the two 5-way HI/LO source-mux selects and the HI/LO write enables.
- Stalls later HI/LO instructions and MFHI/MFLO until the pending write lands.
- Sits between the control unit and the HI/LO muxes/registers.

Parameters:
- TIMEOUT, 64, max cycles to wait for mul_done/div_done before aborting with err.
- CNT_W, 7, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  ID presents a HI/LO-writing instruction.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved, ignored.
- op_ready  out  1  op accepted this cycle (op_valid & op_ready).
- divisor_zero  in  1  divisor==0, sampled with op.
- mf_req  in  1  MFHI/MFLO in ID.
- cancel  in  1  exception flush; aborts the pending op.
- mul_start  out  1  one-cycle start pulse to multiplier.
- div_start  out  1  one-cycle start pulse to divider.
- mul_done  in  1  multiplier result valid (level or pulse).
- div_done  in  1  divider result valid.
- hi_sel  out  3  HI mux select: 000 rs, 001 mult hi, 010 multu hi, 011 div rem, 100 divu rem.
- lo_sel  out  3  LO mux select, same codes (quotient for div).
- hi_we  out  1  HI register write enable.
- lo_we  out  1  LO register write enable.
- stall  out  1  pipeline stall request.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except op_ready=1. hi_sel=lo_sel=000, counter 0, latched op cleared.
- States: IDLE, MUL_WAIT, DIV_WAIT, WRITE.
- All outputs are registered except op_ready and stall, which are combinational from state and inputs.
- Sel codes are always within 000–100. The sels hold their last written value when we=0; they never float.
- op_ready=1 only in IDLE with cancel=0.

IDLE, op accepted at cycle N:
- MULT/MULTU: mul_start=1 in cycle N+1, state MUL_WAIT.
- DIV/DIVU with divisor_zero=0: div_start=1 in N+1, state DIV_WAIT.
- DIV/DIVU with divisor_zero=1: no start, no write, HI/LO unchanged, stay IDLE.
- MTHI/MTLO: state WRITE in N+1 with sel 000 on the targeted register and only that register's we=1.
- Reserved op: ignored, stay IDLE.

MUL_WAIT/DIV_WAIT:
- Counter increments every cycle.
- done seen in cycle M -> WRITE in M+1, hi_we=lo_we=1, sels per latched op (MULT 001/001, MULTU 010/010, DIV 011/011, DIVU 100/100).
- Counter reaching TIMEOUT without done -> err=1, IDLE, no write.
- The wrong unit's done is ignored.

WRITE:
- Lasts exactly one cycle, then IDLE.
- cancel is ignored here; the write is architecturally committed.

cancel:
- In MUL_WAIT/DIV_WAIT: IDLE next cycle, no write, counter cleared.
- In IDLE: blocks acceptance that cycle.

stall:
- stall = (state!=IDLE) & (op_valid | mf_req).
- In IDLE with no pending op, mf_req does not stall.
- MFHI in the cycle after WRITE reads the new value (register write-before-read).
- Simultaneous op_valid and mf_req in IDLE: op accepted, no stall that cycle. MF ordering is resolved by the pipeline, since MF precedes the op.

Decomposition:
- Package hilo_pkg:
  - op codes OP_MULT..OP_MTLO.
  - sel codes SEL_RS, SEL_MUL, SEL_MULU, SEL_DIV, SEL_DIVU (3-bit).
  - state enum.
- One sub-module is natural: hilo_wait_cnt, the timeout counter with clear/enable/expired.

Test Plan:
- MULT accepted at cycle 10, mul_done at 15 -> mul_start at 11; stall high 11–16 while mf_req=1; WRITE at 16 with hi_sel=lo_sel=001, hi_we=lo_we=1; op_ready=1 at 17.
- MTLO at cycle 5 -> cycle 6: lo_we=1, lo_sel=000, hi_we=0; IDLE at 7; no start pulses.
- DIVU with divisor_zero=1 -> no div_start, no we, op_ready stays 1; DIVU with nonzero divisor, div_done after 33 cycles -> sels 100/100, both we=1.
- DIV in flight, cancel at wait cycle 4 -> IDLE next cycle, hi_we=lo_we=0 throughout; a late div_done is ignored.
- TIMEOUT=64, mul_done never asserts -> err=1 at wait cycle 64, state IDLE, no we; err stays 1 through later ops until rst_n=0.
- rst_n pulled low mid-DIV_WAIT -> all outputs 0 (op_ready=1) immediately, independent of clk; after release, MTHI completes normally.

Source files
------------

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op codes, mux select codes and states for the HI/LO sequencer
// Purpose: op encodings from ID, HI/LO mux select encodings, the sequencer
//          state enum, and the op-to-select mapping for unit results.
// Ports:   none (package).
package hilo_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [2:0] SEL_RS   = 3'b000;
   localparam logic [2:0] SEL_MUL  = 3'b001;
   localparam logic [2:0] SEL_MULU = 3'b010;
   localparam logic [2:0] SEL_DIV  = 3'b011;
   localparam logic [2:0] SEL_DIVU = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL_WAIT,
      ST_DIV_WAIT,
      ST_WRITE
   } hilo_state_t;

   // The same code drives both muxes: HI takes hi/remainder, LO takes lo/quotient.
   function automatic logic [2:0] result_sel(input logic [2:0] op);
      case (op)
         OP_MULT:  result_sel = SEL_MUL;
         OP_MULTU: result_sel = SEL_MULU;
         OP_DIV:   result_sel = SEL_DIV;
         OP_DIVU:  result_sel = SEL_DIVU;
         default:  result_sel = SEL_RS;
      endcase
   endfunction

endpackage

// File: rtl/hilo_wait_cnt.sv
// rtl/hilo_wait_cnt.sv - wait-cycle counter with timeout detect for the mul/div wait states
// Purpose: counts cycles spent waiting on the multiplier/divider.
// Ports:   clk, rst_n  - clock, async active-low reset
//          clr         - synchronous clear (wins over en)
//          en          - count this cycle
//          expired     - this is the TIMEOUT-th counted cycle (or later)
module hilo_wait_cnt #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // cnt holds k-1 during the k-th wait cycle, so this fires on wait cycle TIMEOUT.
   assign expired = (cnt >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/hilo_seq_ctrl.sv
// rtl/hilo_seq_ctrl.sv - HI/LO write-path sequencer: launches mul/div, drives HI/LO selects and enables
// Purpose: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, pulses the unit start,
//          waits for done (bounded by TIMEOUT), then writes HI/LO for one cycle.
// Ports:   op_valid/op/op_ready  - op handshake from ID (op_ready combinational)
//          divisor_zero          - sampled with a DIV/DIVU op; suppresses it
//          mf_req, stall         - MFHI/MFLO presence and stall request (combinational)
//          cancel                - flush; aborts a pending mul/div wait
//          mul_start, div_start  - one-cycle start pulses (registered)
//          mul_done, div_done    - unit result valid
//          hi_sel, lo_sel        - HI/LO source mux selects (registered, held)
//          hi_we, lo_we          - HI/LO write enables (registered)
//          err                   - sticky timeout flag
module hilo_seq_ctrl
   import hilo_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       op_valid,
   input  logic [2:0] op,
   output logic       op_ready,
   input  logic       divisor_zero,
   input  logic       mf_req,
   input  logic       cancel,
   output logic       mul_start,
   output logic       div_start,
   input  logic       mul_done,
   input  logic       div_done,
   output logic [2:0] hi_sel,
   output logic [2:0] lo_sel,
   output logic       hi_we,
   output logic       lo_we,
   output logic       stall,
   output logic       err
);

   hilo_state_t state, state_nxt;
   logic [2:0]  op_q, op_nxt;
   logic [2:0]  hi_sel_nxt, lo_sel_nxt;
   logic        mul_start_nxt, div_start_nxt;
   logic        hi_we_nxt, lo_we_nxt, err_nxt;
   logic        in_wait, cnt_clr, expired;

   assign in_wait = (state == ST_MUL_WAIT) || (state == ST_DIV_WAIT);
   // Clearing on any exit from a wait state leaves the counter at zero for the next op.
   assign cnt_clr = !in_wait || (state_nxt != state);

   hilo_wait_cnt #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wait_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (cnt_clr),
      .en      (in_wait),
      .expired (expired)
   );

   assign op_ready = (state == ST_IDLE) && !cancel;
   assign stall    = (state != ST_IDLE) && (op_valid || mf_req);

   always_comb begin
      state_nxt     = state;
      op_nxt        = op_q;
      hi_sel_nxt    = hi_sel;
      lo_sel_nxt    = lo_sel;
      mul_start_nxt = 1'b0;
      div_start_nxt = 1'b0;
      hi_we_nxt     = 1'b0;
      lo_we_nxt     = 1'b0;
      err_nxt       = err;

      case (state)
         ST_IDLE: begin
            if (op_valid && op_ready) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     op_nxt        = op;
                     mul_start_nxt = 1'b1;
                     state_nxt     = ST_MUL_WAIT;
                  end
                  OP_DIV, OP_DIVU: begin
                     // Divide by zero is architecturally a no-op on HI/LO.
                     if (!divisor_zero) begin
                        op_nxt        = op;
                        div_start_nxt = 1'b1;
                        state_nxt     = ST_DIV_WAIT;
                     end
                  end
                  OP_MTHI: begin
                     hi_sel_nxt = SEL_RS;
                     hi_we_nxt  = 1'b1;
                     state_nxt  = ST_WRITE;
                  end
                  OP_MTLO: begin
                     lo_sel_nxt = SEL_RS;
                     lo_we_nxt  = 1'b1;
                     state_nxt  = ST_WRITE;
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL_WAIT, ST_DIV_WAIT: begin
            // Priority: cancel, then done, then timeout (done on the last wait cycle still lands).
            if (cancel) begin
               state_nxt = ST_IDLE;
            end else if ((state == ST_MUL_WAIT) ? mul_done : div_done) begin
               hi_sel_nxt = result_sel(op_q);
               lo_sel_nxt = result_sel(op_q);
               hi_we_nxt  = 1'b1;
               lo_we_nxt  = 1'b1;
               state_nxt  = ST_WRITE;
            end else if (expired) begin
               err_nxt   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_WRITE: begin
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         op_q      <= '0;
         hi_sel    <= SEL_RS;
         lo_sel    <= SEL_RS;
         mul_start <= 1'b0;
         div_start <= 1'b0;
         hi_we     <= 1'b0;
         lo_we     <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         op_q      <= op_nxt;
         hi_sel    <= hi_sel_nxt;
         lo_sel    <= lo_sel_nxt;
         mul_start <= mul_start_nxt;
         div_start <= div_start_nxt;
         hi_we     <= hi_we_nxt;
         lo_we     <= lo_we_nxt;
         err       <= err_nxt;
      end
   end

endmodule
